// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between NUM_REQ requesters.
// One whole transaction (read or write) is granted at a time; payloads are muxed by grant.
module axi_lite_rr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      s_axi_awaddr,
    input  logic [NUM_REQ*3-1:0]               s_axi_awprot,
    input  logic [NUM_REQ-1:0]                 s_axi_awvalid,
    output logic [NUM_REQ-1:0]                 s_axi_awready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      s_axi_wdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  s_axi_wstrb,
    input  logic [NUM_REQ-1:0]                 s_axi_wvalid,
    output logic [NUM_REQ-1:0]                 s_axi_wready,
    output logic [NUM_REQ*2-1:0]               s_axi_bresp,
    output logic [NUM_REQ-1:0]                 s_axi_bvalid,
    input  logic [NUM_REQ-1:0]                 s_axi_bready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      s_axi_araddr,
    input  logic [NUM_REQ*3-1:0]               s_axi_arprot,
    input  logic [NUM_REQ-1:0]                 s_axi_arvalid,
    output logic [NUM_REQ-1:0]                 s_axi_arready,
    output logic [NUM_REQ*DATA_WIDTH-1:0]      s_axi_rdata,
    output logic [NUM_REQ*2-1:0]               s_axi_rresp,
    output logic [NUM_REQ-1:0]                 s_axi_rvalid,
    input  logic [NUM_REQ-1:0]                 s_axi_rready,
    output logic [ADDR_WIDTH-1:0]              m_axi_awaddr,
    output logic [2:0]                         m_axi_awprot,
    output logic                               m_axi_awvalid,
    input  logic                               m_axi_awready,
    output logic [DATA_WIDTH-1:0]              m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]            m_axi_wstrb,
    output logic                               m_axi_wvalid,
    input  logic                               m_axi_wready,
    input  logic [1:0]                         m_axi_bresp,
    input  logic                               m_axi_bvalid,
    output logic                               m_axi_bready,
    output logic [ADDR_WIDTH-1:0]              m_axi_araddr,
    output logic [2:0]                         m_axi_arprot,
    output logic                               m_axi_arvalid,
    input  logic                               m_axi_arready,
    input  logic [DATA_WIDTH-1:0]              m_axi_rdata,
    input  logic [1:0]                         m_axi_rresp,
    input  logic                               m_axi_rvalid,
    output logic                               m_axi_rready,
    output logic [NUM_REQ-1:0]                 grant,
    output logic [2:0]                         dbg_state
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4
    } state_t;

    state_t               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [IW-1:0]        gidx_q;
    logic [IW-1:0]        ptr_q;
    logic                 aw_done_q, w_done_q;
    logic                 aw_done_d, w_done_d;
    logic [NUM_REQ-1:0]   req;
    logic                 win_found;
    logic [IW-1:0]        win_idx;
    logic                 aw_active, w_active;

    assign req       = s_axi_awvalid | s_axi_arvalid;
    assign grant     = grant_q;
    assign dbg_state = state_q;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    assign aw_active = (state_q == WR_AW_W) && !aw_done_q;
    assign w_active  = (state_q == WR_AW_W) && !w_done_q;

    always_comb begin
        m_axi_awaddr  = s_axi_awaddr[int'(gidx_q)*ADDR_WIDTH +: ADDR_WIDTH];
        m_axi_awprot  = s_axi_awprot[int'(gidx_q)*3 +: 3];
        m_axi_awvalid = aw_active && s_axi_awvalid[gidx_q];
        m_axi_wdata   = s_axi_wdata[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
        m_axi_wstrb   = s_axi_wstrb[int'(gidx_q)*SW +: SW];
        m_axi_wvalid  = w_active && s_axi_wvalid[gidx_q];
        m_axi_bready  = (state_q == WR_B) && s_axi_bready[gidx_q];
        m_axi_araddr  = s_axi_araddr[int'(gidx_q)*ADDR_WIDTH +: ADDR_WIDTH];
        m_axi_arprot  = s_axi_arprot[int'(gidx_q)*3 +: 3];
        m_axi_arvalid = (state_q == RD_AR) && s_axi_arvalid[gidx_q];
        m_axi_rready  = (state_q == RD_R) && s_axi_rready[gidx_q];
    end

    // Requester-side responses are gated by grant so non-owners see all zeros.
    always_comb begin
        s_axi_awready = '0;
        s_axi_wready  = '0;
        s_axi_bresp   = '0;
        s_axi_bvalid  = '0;
        s_axi_arready = '0;
        s_axi_rdata   = '0;
        s_axi_rresp   = '0;
        s_axi_rvalid  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            s_axi_awready[i] = grant_q[i] && aw_active && m_axi_awready;
            s_axi_wready[i]  = grant_q[i] && w_active && m_axi_wready;
            s_axi_arready[i] = grant_q[i] && (state_q == RD_AR) && m_axi_arready;
            if (grant_q[i] && (state_q == WR_B)) begin
                s_axi_bresp[2*i +: 2] = m_axi_bresp;
                s_axi_bvalid[i]       = m_axi_bvalid;
            end
            if (grant_q[i] && (state_q == RD_R)) begin
                s_axi_rdata[i*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
                s_axi_rresp[2*i +: 2]                   = m_axi_rresp;
                s_axi_rvalid[i]                         = m_axi_rvalid;
            end
        end
    end

    assign aw_done_d = aw_done_q || (m_axi_awvalid && m_axi_awready);
    assign w_done_d  = w_done_q || (m_axi_wvalid && m_axi_wready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= IW'(NUM_REQ - 1);
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    if (win_found) begin
                        grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                        gidx_q  <= win_idx;
                        // A winner with both channels pending is served as a write first.
                        state_q <= s_axi_awvalid[win_idx] ? WR_AW_W : RD_AR;
                    end
                end
                WR_AW_W: begin
                    if (aw_done_d && w_done_d) begin
                        state_q   <= WR_B;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else begin
                        aw_done_q <= aw_done_d;
                        w_done_q  <= w_done_d;
                    end
                end
                WR_B: begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        state_q <= IDLE;
                        ptr_q   <= gidx_q;
                        grant_q <= '0;
                    end
                end
                RD_AR: begin
                    if (m_axi_arvalid && m_axi_arready) state_q <= RD_R;
                end
                RD_R: begin
                    if (m_axi_rvalid && m_axi_rready) begin
                        state_q <= IDLE;
                        ptr_q   <= gidx_q;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end
endmodule
